// File: rtl/trap_scheduler.sv
// Trap sequencer for the MegaMapper virtualization logic: collects trap requests,
// arbitrates them by fixed priority and sequences NMI entry/exit at Z80 fetch boundaries.
module trap_scheduler #(
    parameter int unsigned NMI_LEN  = 4,
    parameter int unsigned COOLDOWN = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       m1_n,
    input  logic       new_isr,
    input  logic       last_isr_jmp,
    input  logic       virtual_enabled,
    input  logic       io_violation,
    input  logic       irq_sys_n,
    input  logic       timer_tick,
    input  logic       sw_trap,
    input  logic       cause_clr,
    input  logic [3:0] cause_clr_mask,
    output logic       trap_state,
    output logic       nmi_n,
    output logic       capture_address,
    output logic [3:0] trap_cause,
    output logic [3:0] pending
);

    // Handshake: there are no valid/ready pairs here; every strobe input is
    // edge-detected, cause_clr is a single-cycle command and outputs are levels.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_NMI     = 2'd1,
        ST_SERVICE = 2'd2,
        ST_COOL    = 2'd3
    } state_t;

    localparam logic [3:0] NMI_LEN_C  = 4'(NMI_LEN);
    localparam logic [3:0] COOLDOWN_C = 4'(COOLDOWN);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] trap_cause_q, trap_cause_d;
    logic       capture_q, capture_d;
    logic [3:0] pending_q, pending_d;

    logic       m1_s1_q, m1_s1_d;
    logic       m1_s2_q, m1_s2_d;
    logic       m1_last_q, m1_last_d;
    logic       new_s1_q, new_s1_d;
    logic       new_s2_q, new_s2_d;
    logic       jmp_s1_q, jmp_s1_d;
    logic       jmp_s2_q, jmp_s2_d;
    logic       m1_fall_q, m1_fall_d;
    logic       new_isr_q, new_isr_d;
    logic       last_jmp_q, last_jmp_d;

    // Strobe samples, ordered {sw, timer, io}
    logic [2:0] strb_q, strb_d;
    logic [2:0] strb_dly_q, strb_dly_d;
    logic [2:0] strb_rise;

    logic [3:0] clr_vec;
    logic       take;
    logic       svc_exit;

    function automatic logic [3:0] pick_cause(input logic [3:0] p);
        logic [3:0] r;
        r = 4'b0000;
        if (p[0])      r = 4'b0001;
        else if (p[1]) r = 4'b0010;
        else if (p[2]) r = 4'b0100;
        else if (p[3]) r = 4'b1000;
        return r;
    endfunction

    // Qualifiers travel through the same two stages as m1_n so they line up with m1_fall.
    always_comb begin
        m1_s1_d    = m1_n;
        m1_s2_d    = m1_s1_q;
        m1_last_d  = m1_s2_q;
        new_s1_d   = new_isr;
        new_s2_d   = new_s1_q;
        jmp_s1_d   = last_isr_jmp;
        jmp_s2_d   = jmp_s1_q;
        m1_fall_d  = m1_last_q & ~m1_s2_q;
        new_isr_d  = new_s2_q;
        last_jmp_d = jmp_s2_q;
    end

    always_comb begin
        strb_d     = {sw_trap, timer_tick, io_violation};
        strb_dly_d = strb_q;
        strb_rise  = strb_q & ~strb_dly_q;
    end

    // Sticky bits: a set in the same cycle as a clear wins.
    always_comb begin
        clr_vec      = cause_clr ? cause_clr_mask : 4'b0000;
        pending_d[0] = (pending_q[0] & ~clr_vec[0]) | (strb_rise[0] & ~trap_state);
        pending_d[1] = ~irq_sys_n;
        pending_d[2] = (pending_q[2] & ~clr_vec[2]) | strb_rise[1];
        pending_d[3] = (pending_q[3] & ~clr_vec[3]) | strb_rise[2];
    end

    always_comb begin
        take     = virtual_enabled && (state_q == ST_IDLE) && m1_fall_q
                   && new_isr_q && (pending_q != 4'b0000);
        svc_exit = (state_q == ST_SERVICE) && m1_fall_q && last_jmp_q;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take) state_d = ST_NMI;
            end
            ST_NMI: begin
                if (cnt_q <= 4'd1) state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (svc_exit) state_d = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
            end
            ST_COOL: begin
                if (m1_fall_q && (cnt_q <= 4'd1)) state_d = ST_IDLE;
            end
            default: state_d = ST_SERVICE;
        endcase
        if (!virtual_enabled) state_d = ST_SERVICE;
    end

    // Shared counter: NMI pulse length in clk, then cooldown length in M1 cycles.
    always_comb begin
        cnt_d = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take) cnt_d = NMI_LEN_C;
            end
            ST_NMI: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            ST_SERVICE: begin
                if (svc_exit) cnt_d = COOLDOWN_C;
            end
            ST_COOL: begin
                if (m1_fall_q && (cnt_q != 4'd0)) cnt_d = cnt_q - 4'd1;
            end
            default: cnt_d = 4'd0;
        endcase
        if (!virtual_enabled) cnt_d = 4'd0;
    end

    always_comb begin
        trap_cause_d = trap_cause_q;
        capture_d    = capture_q;
        if (take) begin
            trap_cause_d = pick_cause(pending_q);
            capture_d    = 1'b1;
        end else if (m1_fall_q) begin
            capture_d    = 1'b0;
        end
    end

    // Outputs decode straight from the state register so reset releases nmi_n at once.
    always_comb begin
        trap_state      = (state_q == ST_NMI) || (state_q == ST_SERVICE);
        nmi_n           = (state_q != ST_NMI);
        capture_address = capture_q;
        trap_cause      = trap_cause_q;
        pending         = pending_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SERVICE;
            cnt_q        <= 4'd0;
            trap_cause_q <= 4'd0;
            capture_q    <= 1'b0;
            pending_q    <= 4'd0;
            m1_s1_q      <= 1'b1;
            m1_s2_q      <= 1'b1;
            m1_last_q    <= 1'b1;
            new_s1_q     <= 1'b0;
            new_s2_q     <= 1'b0;
            jmp_s1_q     <= 1'b0;
            jmp_s2_q     <= 1'b0;
            m1_fall_q    <= 1'b0;
            new_isr_q    <= 1'b0;
            last_jmp_q   <= 1'b0;
            strb_q       <= 3'd0;
            strb_dly_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trap_cause_q <= trap_cause_d;
            capture_q    <= capture_d;
            pending_q    <= pending_d;
            m1_s1_q      <= m1_s1_d;
            m1_s2_q      <= m1_s2_d;
            m1_last_q    <= m1_last_d;
            new_s1_q     <= new_s1_d;
            new_s2_q     <= new_s2_d;
            jmp_s1_q     <= jmp_s1_d;
            jmp_s2_q     <= jmp_s2_d;
            m1_fall_q    <= m1_fall_d;
            new_isr_q    <= new_isr_d;
            last_jmp_q   <= last_jmp_d;
            strb_q       <= strb_d;
            strb_dly_q   <= strb_dly_d;
        end
    end

endmodule

// File: doc/trap_scheduler.md
# trap_scheduler

Clocked trap sequencer for the MegaMapper virtualization logic. It collects trap requests from four sources: I/O violation, system IRQ, hypervisor timer and software trap. It arbitrates them by fixed priority and enters trap mode only at an instruction-fetch boundary. On entry it emits a timed NMI pulse to the Z80, exposes the winning cause to the hypervisor, and releases trap mode when the hypervisor exits through its final jump.

## Interface
- NMI_LEN, 4: width of the nmi_n low pulse, in clk cycles (1..15).
- COOLDOWN, 2: number of M1 cycles to wait after trap exit before the next trap may be taken (0..15).

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- m1_n  in  1  raw Z80 M1, asynchronous to clk
- new_isr  in  1  current fetch is a legal trap-insertion point; sampled alongside m1_n
- last_isr_jmp  in  1  current fetch is the hypervisor's exit jump; sampled alongside m1_n
- virtual_enabled  in  1  virtualization enable, synchronous to clk
- io_violation  in  1  I/O violation strobe; a rising edge is one event
- irq_sys_n  in  1  system interrupt, level, active-low
- timer_tick  in  1  hypervisor timer strobe; a rising edge is one event
- sw_trap  in  1  software trap strobe; a rising edge is one event
- cause_clr  in  1  one-clk pulse that clears the pending bits selected by cause_clr_mask
- cause_clr_mask  in  4  bit mask for cause_clr
- trap_state  out  1  high while in trap mode
- nmi_n  out  1  NMI to the CPU, active-low
- capture_address  out  1  address-capture enable for the trapped fetch
- trap_cause  out  4  one-hot winning cause, latched at trap entry
- pending  out  4  current pending vector

## Operation
**Input conditioning**
- m1_n, new_isr and last_isr_jmp each pass through a 2-flop synchronizer.
- m1_fall is true for one clk when the synchronized m1_n goes 1→0. The qualifiers are taken from the same synchronizer stage as m1_n.

**Pending vector** (bit0 = io, bit1 = irq, bit2 = timer, bit3 = sw)
- bit0 is sticky. It is set on a rising edge of io_violation only while trap_state=0; edges seen while trap_state=1 are ignored.
- bit1 is not sticky. It equals the registered value of !irq_sys_n.
- bit2 and bit3 are sticky. They are set on rising edges of their strobes.
- cause_clr clears the sticky bits selected by the mask. If a set and a clear hit the same bit in the same cycle, the set wins. The mask bit for bit1 has no effect.

**Arbitration**
- Fixed priority: io > irq > timer > sw.
- trap_cause receives the one-hot of the highest pending bit and changes only at trap entry.

**States**
- IDLE (trap_state=0): on m1_fall with new_isr=1 and pending≠0, go to NMI. In the same cycle, latch trap_cause, set capture_address=1 and load the NMI counter with NMI_LEN.
- NMI (trap_state=1, nmi_n=0): decrement the counter each clk; at 0, go to SERVICE. last_isr_jmp is ignored in this state.
- SERVICE (trap_state=1, nmi_n=1): on m1_fall with last_isr_jmp=1, go to COOLDOWN. If COOLDOWN=0, go directly to IDLE instead.
- COOLDOWN (trap_state=0): decrement the counter on each m1_fall; at 0, go to IDLE. Requests continue to accumulate in pending during this state.
- Whenever virtual_enabled=0, the state is forced to SERVICE on the next clk and any NMI pulse in progress is truncated (nmi_n returns high). SERVICE can only be exited while virtual_enabled=1.

**capture_address**
- Clears on the first m1_fall after the one that set it.

## Timing
**Reset values**
- State SERVICE, trap_state=1, nmi_n=1, capture_address=0, trap_cause=0, pending=0, all counters 0.

**Latencies**
- m1_n low must be met by a clk edge; m1_fall occurs 2 clk later and the state/outputs update on the following edge, 3 clk in total.
- A strobe edge reaches pending 2 clk after the input rises: 1 clk for edge detection plus 1 clk for the register.
- nmi_n goes low in the same cycle that trap_state rises, and stays low for exactly NMI_LEN clk.

**Boundary conditions**
- A request arriving in the same cycle as m1_fall in IDLE is not taken at that fetch; it is taken at the next qualifying fetch.
- With several bits pending, exactly one bit is set in trap_cause.
- Clearing pending while in NMI or SERVICE has no effect on trap_cause.
- Pending bits that were not serviced re-trap at the first qualifying fetch after COOLDOWN completes.
- Asserting reset_n low mid-pulse immediately forces nmi_n=1.

## Test plan
- After reset, set virtual_enabled=1 and present m1_fall with last_isr_jmp=1 → COOLDOWN; after 2 further m1_fall with no pending → IDLE with trap_state=0, nmi_n=1.
- In IDLE, pulse io_violation and timer_tick together, then m1_fall with new_isr=1 → trap_cause=0001, pending=0101, nmi_n low for exactly 4 clk, capture_address high until the next m1_fall.
- Hold irq_sys_n=0 and take a trap → trap_cause=0010; exit, release irq_sys_n, issue cause_clr mask=1111 → pending=0000, and no further trap occurs on later new_isr fetches.
- Pulse io_violation while trap_state=1 → pending bit0 stays 0; pulse sw_trap in the same cycle as cause_clr with mask=1000 → bit3=1.
- Clear virtual_enabled 2 clk into the NMI pulse → nmi_n=1 on the next clk, trap_state=1, and last_isr_jmp fetches do not exit until virtual_enabled=1 again.
